// File: rtl/transition_detector_pkg.sv
// Shared state encodings, edge-mode constants and width helper for the transition detector.
package transition_detector_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_LOW  = 2'b01,
        S_HIGH = 2'b10
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_fsm_ch.sv
// Single-channel edge FSM with Mealy edge flag and saturating transition counter.
// Latency: flag combinational, counter updates next clk; no backpressure.
module edge_fsm_ch
    import transition_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             i,
    input  logic             clr,
    output logic             j,
    output logic [CNT_W-1:0] cnt
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // State follows the input even while disabled, so re-enabling sees no stale edge.
    always_comb begin
        state_d = S_INIT;
        j       = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = i ? S_HIGH : S_LOW;
            end
            S_LOW: begin
                state_d = i ? S_HIGH : S_LOW;
                j       = en & i & mode[0];
            end
            S_HIGH: begin
                state_d = i ? S_HIGH : S_LOW;
                j       = en & ~i & mode[1];
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (j && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transition_detector.sv
// N-channel transition detector: per-channel edge flags, registered flags and selectable counts.
// Latency: j/any/count combinational, j_q one clk; no backpressure.
module transition_detector
    import transition_detector_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int CNT_W = 8,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     i,
    input  logic             clr,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     j,
    output logic [N-1:0]     j_q,
    output logic             any,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_arr [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        edge_fsm_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .mode (mode),
            .i    (i[k]),
            .clr  (clr),
            .j    (j[k]),
            .cnt  (cnt_arr[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j_q <= '0;
        end else begin
            j_q <= j;
        end
    end

    assign any = |j;

    // Out-of-range select matches no channel and reads as zero.
    always_comb begin
        count = '0;
        for (int k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                count = cnt_arr[k];
            end
        end
    end

endmodule
